change_dispenser: RTL

- Pays out a refund or change amount as physical coins, one coin at a time, to the coin hopper. This is the outgoing-coin counterpart of the balance accumulator, which takes coins in.
- Vending control requests a payout in nickel units. The block pays with dimes first and uses nickels for any odd remainder or when the dime tube is empty.
- Each coin is driven as a timed pulse, gated by a ready handshake from the hopper.

---
 rtl/change_dispenser_if.sv | 33 +++
 rtl/change_dispenser.sv | 91 +++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, hopper handshake and coin-pulse bundle of change_dispenser
//   i_start        - payout request, sampled only when idle
//   i_amount       - payout amount in nickel units, latched on accepted start
//   i_hopper_ready - hopper can take a coin command this cycle
//   i_dime_empty   - dime tube empty, sampled at each coin selection
//   o_dime_out     - dime eject pulse
//   o_nickel_out   - nickel eject pulse
//   o_busy         - payout in progress (any state but idle)
//   o_done         - one-cycle completion pulse
//   o_dimes_paid   - dimes ejected in the current or last payout
//   o_nickels_paid - nickels ejected in the current or last payout
interface change_dispenser_if #(
    parameter int BAL_W = 5
);
    logic             i_start;
    logic [BAL_W-1:0] i_amount;
    logic             i_hopper_ready;
    logic             i_dime_empty;
    logic             o_dime_out;
    logic             o_nickel_out;
    logic             o_busy;
    logic             o_done;
    logic [3:0]       o_dimes_paid;
    logic [4:0]       o_nickels_paid;
    modport slave (
        input  i_start, i_amount, i_hopper_ready, i_dime_empty,
        output o_dime_out, o_nickel_out, o_busy, o_done, o_dimes_paid, o_nickels_paid
    );
    modport master (
        output i_start, i_amount, i_hopper_ready, i_dime_empty,
        input  o_dime_out, o_nickel_out, o_busy, o_done, o_dimes_paid, o_nickels_paid
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays a nickel-unit amount out as timed dime/nickel pulses to a coin hopper
//   clk - system clock
//   rst - synchronous active-low reset
//   bus - change_dispenser_if.slave: payout request, hopper handshake, coin pulses, status
module change_dispenser #(
    parameter int BAL_W        = 5,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);
    localparam int CW = $clog2((PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES) + 1);
    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
    state_t           r_state;
    logic [BAL_W-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_dime;
    logic             r_nickel;
    logic             r_busy;
    logic             r_done;
    logic [3:0]       r_dimes;
    logic [4:0]       r_nickels;
    logic             w_pick_dime;
    // Dimes first; a nickel covers an odd remainder or an empty dime tube
    assign w_pick_dime = (r_rem >= BAL_W'(2)) && !bus.i_dime_empty;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dime    <= 1'b0;
            r_nickel  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dimes   <= '0;
            r_nickels <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.i_start) begin
                    r_rem     <= bus.i_amount;
                    r_dimes   <= '0;
                    r_nickels <= '0;
                    r_busy    <= 1'b1;
                    r_done    <= bus.i_amount == '0;
                    r_state   <= bus.i_amount == '0 ? DONE : SELECT;
                end
                SELECT: if (r_rem == '0) begin
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end else if (bus.i_hopper_ready) begin
                    // Coin output is registered here so it rises together with PULSE
                    r_dime   <= w_pick_dime;
                    r_nickel <= !w_pick_dime;
                    r_rem    <= r_rem - (w_pick_dime ? BAL_W'(2) : BAL_W'(1));
                    if (w_pick_dime) r_dimes <= r_dimes + 4'd1;
                    else r_nickels <= r_nickels + 5'd1;
                    r_cnt    <= '0;
                    r_state  <= PULSE;
                end
                PULSE: if (r_cnt == CW'(PULSE_CYCLES - 1)) begin
                    r_dime   <= 1'b0;
                    r_nickel <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= GAP;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                GAP: if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                    r_cnt   <= '0;
                    r_state <= SELECT;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.o_dime_out     = r_dime;
    assign bus.o_nickel_out   = r_nickel;
    assign bus.o_busy         = r_busy;
    assign bus.o_done         = r_done;
    assign bus.o_dimes_paid   = r_dimes;
    assign bus.o_nickels_paid = r_nickels;
endmodule
